// File: rtl/jt7759_pkg.sv
// Shared definitions for the JT7759 slave-mode data feeder.
// Latency: none, this file holds types and constants only.
// Backpressure: none, this file holds types and constants only.
package jt7759_pkg;

   // Default FIFO address width; depth is 2**FEED_AW bytes.
   localparam int FEED_AW = 4;

   // Request handler states, one-hot encoded.
   typedef enum logic [3:0] {
      ST_IDLE  = 4'b0001,
      ST_WAIT  = 4'b0010,
      ST_SERVE = 4'b0100,
      ST_HOLD  = 4'b1000
   } feed_state_t;

   // Fill level that a FIFO of address width aw reports when it is full.
   function automatic int fifo_depth(input int aw);
      return 2 ** aw;
   endfunction

endpackage

// File: rtl/jt7759_fifo.sv
// Synchronous byte FIFO built from a register array, with flush.
// Latency: a pushed byte is at the head 1 cycle later; level is registered.
// Backpressure: pushes while full are ignored; pops while empty are ignored.
module jt7759_fifo #(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic [7:0]    push_dat,
   input  logic          pop,
   output logic [7:0]    pop_dat,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level,
   output logic [AW:0]   level_nxt
);

   localparam int DEPTH = 2 ** AW;

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] wr_nxt;
   logic [AW:0] rd_nxt;
   logic        do_push;
   logic        do_pop;

   // The extra pointer MSB tells full apart from empty when the low bits match.
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);

   // Flush overrides both ports so a clear never lets a byte slip through.
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   assign pop_dat = mem[rd_ptr[AW-1:0]];

   // Post-update pointers and fill count, used for the registered level.
   always_comb begin
      wr_nxt = wr_ptr + {{AW{1'b0}}, do_push};
      rd_nxt = rd_ptr + {{AW{1'b0}}, do_pop};
      if (flush) begin
         wr_nxt = '0;
         rd_nxt = '0;
      end
      level_nxt = wr_nxt - rd_nxt;
   end

   // Pointer and level registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         wr_ptr <= wr_nxt;
         rd_ptr <= rd_nxt;
         level  <= level_nxt;
      end
   end

   // Storage array; contents need no reset because the pointers gate every read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_dat;
      end
   end

endmodule

// File: rtl/jt7759_feed.sv
// Slave-mode byte feeder: CPU fills a FIFO, controller ROM requests pop it.
// Latency: request to rom_ok 2 cycles with data ready; empty FIFO adds the wait for a push.
// Backpressure: drq drops near full; writes into a full FIFO are dropped and flag overflow.
module jt7759_feed
   import jt7759_pkg::*;
#(
   parameter int AW      = FEED_AW,
   parameter int DRQ_LVL = 2 ** AW - 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          cpu_wr,
   input  logic [7:0]    cpu_din,
   output logic          drq,
   output logic          overflow,
   output logic [AW:0]   level,
   input  logic          rom_cs,
   input  logic [16:0]   rom_addr,
   output logic [7:0]    rom_data,
   output logic          rom_ok
);

   localparam logic [AW:0] DRQ_TH = (AW + 1)'(DRQ_LVL);

   feed_state_t state;
   logic        cs_l;
   logic [16:0] addr_l;
   logic        req;
   logic        pop_vld;
   logic        fifo_full;
   logic        fifo_empty;
   logic [7:0]  fifo_head;
   logic [AW:0] fifo_level_nxt;

   // A new request is a rising rom_cs, or a new address while rom_cs stays high.
   assign req = rom_cs && (!cs_l || (rom_addr != addr_l));

   // The only pop is the single SERVE cycle, so each request takes at most one byte.
   assign pop_vld = (state == ST_SERVE);

   jt7759_fifo #(
      .AW (AW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (cpu_wr),
      .push_dat  (cpu_din),
      .pop       (pop_vld),
      .pop_dat   (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (level),
      .level_nxt (fifo_level_nxt)
   );

   // Registered copies of the request inputs for edge and address-change detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_l   <= 1'b0;
         addr_l <= '0;
      end else begin
         cs_l   <= rom_cs;
         addr_l <= rom_addr;
      end
   end

   // CPU flow control from the post-update fill count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drq <= 1'b1;
      end else begin
         drq <= (fifo_level_nxt < DRQ_TH);
      end
   end

   // Sticky overflow: a write that finds the FIFO full loses its byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (flush) begin
         overflow <= 1'b0;
      end else if (cpu_wr && fifo_full) begin
         overflow <= 1'b1;
      end
   end

   // Request handler: wait for data, serve one byte, hold it until the request ends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         rom_data <= 8'h00;
         rom_ok   <= 1'b0;
      end else if (flush) begin
         // rom_data is left alone; only the valid flag and the request are dropped.
         state  <= ST_IDLE;
         rom_ok <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (req) begin
                  rom_ok <= 1'b0;
                  state  <= fifo_empty ? ST_WAIT : ST_SERVE;
               end
            end
            ST_WAIT: begin
               // A withdrawn request must not consume a byte, so rom_cs wins.
               if (!rom_cs) begin
                  state <= ST_IDLE;
               end else if (!fifo_empty) begin
                  state <= ST_SERVE;
               end
            end
            ST_SERVE: begin
               rom_data <= fifo_head;
               rom_ok   <= 1'b1;
               state    <= ST_HOLD;
            end
            ST_HOLD: begin
               if (!rom_cs) begin
                  rom_ok <= 1'b0;
                  state  <= ST_IDLE;
               end else if (req) begin
                  rom_ok <= 1'b0;
                  state  <= fifo_empty ? ST_WAIT : ST_SERVE;
               end
            end
            default: begin
               rom_ok <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jt7759_feed.sv
// Directed bench for jt7759_feed: vector table plus hand-written corner sequences.
// Latency: inputs change 1 time unit after a rising edge, outputs are checked there too.
// Backpressure: not applicable; the bench drives the CPU and controller sides directly.
module tb_jt7759_feed;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          cpu_wr;
   logic [7:0]    cpu_din;
   logic          drq;
   logic          overflow;
   logic [AW:0]   level;
   logic          rom_cs;
   logic [16:0]   rom_addr;
   logic [7:0]    rom_data;
   logic          rom_ok;

   int tests = 0;
   int fails = 0;

   jt7759_feed #(.AW(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .cpu_wr   (cpu_wr),
      .cpu_din  (cpu_din),
      .drq      (drq),
      .overflow (overflow),
      .level    (level),
      .rom_cs   (rom_cs),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .rom_ok   (rom_ok)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [7:0]  din;
      logic        cs;
      logic [16:0] addr;
      logic        fl;
      logic        ok;
      logic [7:0]  dat;
      logic [4:0]  lvl;
      logic        drq;
      logic        ovf;
   } vec_t;

   vec_t tbl [22];
   logic [7:0] model_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Safety net so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_b;
      logic [7:0] nxt_b;
      rst = 1'b1; flush = 1'b0; cpu_wr = 1'b0; cpu_din = 8'h00;
      rom_cs = 1'b0; rom_addr = '0;

      // Per row: inputs held for one cycle, then outputs expected after that edge.
      //          wr    din    cs    addr       fl    ok    dat    lvl   drq   ovf
      tbl[0]  = '{1'b1, 8'h5A, 1'b0, 17'h00000, 1'b0, 1'b0, 8'h00, 5'd1, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 8'hA5, 1'b0, 17'h00000, 1'b0, 1'b0, 8'h00, 5'd2, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 8'h00, 1'b1, 17'h00003, 1'b0, 1'b0, 8'h00, 5'd2, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 8'h00, 1'b1, 17'h00003, 1'b0, 1'b1, 8'h5A, 5'd1, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 8'h00, 1'b1, 17'h00003, 1'b0, 1'b1, 8'h5A, 5'd1, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 8'h00, 1'b1, 17'h00004, 1'b0, 1'b0, 8'h5A, 5'd1, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 8'h00, 1'b1, 17'h00004, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 8'h00, 1'b0, 17'h00004, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 8'h00, 1'b1, 17'h00005, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 8'h00, 1'b1, 17'h00005, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 8'h3C, 1'b1, 17'h00005, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 8'h00, 1'b1, 17'h00005, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 8'h00, 1'b1, 17'h00005, 1'b0, 1'b1, 8'h3C, 5'd0, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 8'h00, 1'b0, 17'h00005, 1'b0, 1'b0, 8'h3C, 5'd0, 1'b1, 1'b0};
      tbl[14] = '{1'b0, 8'h00, 1'b1, 17'h00006, 1'b0, 1'b0, 8'h3C, 5'd0, 1'b1, 1'b0};
      tbl[15] = '{1'b0, 8'h00, 1'b1, 17'h00006, 1'b0, 1'b0, 8'h3C, 5'd0, 1'b1, 1'b0};
      tbl[16] = '{1'b0, 8'h00, 1'b1, 17'h00006, 1'b0, 1'b0, 8'h3C, 5'd0, 1'b1, 1'b0};
      tbl[17] = '{1'b0, 8'h00, 1'b0, 17'h00006, 1'b0, 1'b0, 8'h3C, 5'd0, 1'b1, 1'b0};
      tbl[18] = '{1'b1, 8'h11, 1'b0, 17'h00006, 1'b0, 1'b0, 8'h3C, 5'd1, 1'b1, 1'b0};
      tbl[19] = '{1'b0, 8'h00, 1'b0, 17'h00006, 1'b0, 1'b0, 8'h3C, 5'd1, 1'b1, 1'b0};
      tbl[20] = '{1'b0, 8'h00, 1'b0, 17'h00006, 1'b0, 1'b0, 8'h3C, 5'd1, 1'b1, 1'b0};
      tbl[21] = '{1'b0, 8'h00, 1'b0, 17'h00006, 1'b1, 1'b0, 8'h3C, 5'd0, 1'b1, 1'b0};

      // Reset state.
      step();
      check("rst_rom_ok", 32'(rom_ok), 32'd0);
      check("rst_rom_data", 32'(rom_data), 32'h00);
      check("rst_drq", 32'(drq), 32'd1);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      rst = 1'b0;
      step();

      // Basic serve, empty wait, withdrawn request, flush.
      for (int i = 0; i < 22; i++) begin
         cpu_wr = tbl[i].wr; cpu_din = tbl[i].din;
         rom_cs = tbl[i].cs; rom_addr = tbl[i].addr; flush = tbl[i].fl;
         step();
         check($sformatf("vec%0d_rom_ok", i), 32'(rom_ok), 32'(tbl[i].ok));
         check($sformatf("vec%0d_rom_data", i), 32'(rom_data), 32'(tbl[i].dat));
         check($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].lvl));
         check($sformatf("vec%0d_drq", i), 32'(drq), 32'(tbl[i].drq));
         check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(tbl[i].ovf));
      end
      cpu_wr = 1'b0; flush = 1'b0;

      // Fill to full: drq drops once level reaches 14.
      for (int i = 0; i < 16; i++) begin
         cpu_wr = 1'b1; cpu_din = 8'(8'h80 + i);
         step();
         check($sformatf("fill%0d_level", i), 32'(level), 32'(i + 1));
         check($sformatf("fill%0d_drq", i), 32'(drq), ((i + 1) < 14) ? 32'd1 : 32'd0);
         check($sformatf("fill%0d_overflow", i), 32'(overflow), 32'd0);
      end
      cpu_din = 8'hEE;
      step();
      cpu_wr = 1'b0;
      check("ovf_level", 32'(level), 32'd16);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_drq", 32'(drq), 32'd0);
      step();
      check("ovf_sticky", 32'(overflow), 32'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_level", 32'(level), 32'd0);
      check("flush_overflow", 32'(overflow), 32'd0);
      check("flush_drq", 32'(drq), 32'd1);

      // Simultaneous push and pop, 35 transfers through a 16-deep FIFO.
      nxt_b = 8'h20;
      for (int i = 0; i < 4; i++) begin
         cpu_wr = 1'b1; cpu_din = nxt_b; model_q.push_back(nxt_b); nxt_b++;
         step();
      end
      cpu_wr = 1'b0;
      step();
      check("pp_level_init", 32'(level), 32'd4);
      for (int t = 0; t < 35; t++) begin
         rom_cs = 1'b1; rom_addr = 17'(17'h100 + t);
         step();
         check($sformatf("pp%0d_ok_early", t), 32'(rom_ok), 32'd0);
         cpu_wr = 1'b1; cpu_din = nxt_b; model_q.push_back(nxt_b); nxt_b++;
         step();
         cpu_wr = 1'b0;
         exp_b = model_q.pop_front();
         check($sformatf("pp%0d_ok", t), 32'(rom_ok), 32'd1);
         check($sformatf("pp%0d_data", t), 32'(rom_data), 32'(exp_b));
         check($sformatf("pp%0d_level", t), 32'(level), 32'd4);
         rom_cs = 1'b0;
         step();
         check($sformatf("pp%0d_ok_drop", t), 32'(rom_ok), 32'd0);
      end

      // Reset while holding a served byte.
      rom_cs = 1'b1; rom_addr = 17'h00200;
      step();
      step();
      check("hold_ok", 32'(rom_ok), 32'd1);
      check("hold_data", 32'(rom_data), 32'(model_q[0]));
      rst = 1'b1;
      #1;
      check("arst_rom_ok", 32'(rom_ok), 32'd0);
      check("arst_rom_data", 32'(rom_data), 32'h00);
      check("arst_level", 32'(level), 32'd0);
      check("arst_drq", 32'(drq), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("post_rst_wait%0d_ok", i), 32'(rom_ok), 32'd0);
      end
      cpu_wr = 1'b1; cpu_din = 8'h77;
      step();
      cpu_wr = 1'b0;
      check("post_rst_push_level", 32'(level), 32'd1);
      check("post_rst_push_ok", 32'(rom_ok), 32'd0);
      step();
      check("post_rst_serve_ok", 32'(rom_ok), 32'd0);
      step();
      check("post_rst_ok", 32'(rom_ok), 32'd1);
      check("post_rst_data", 32'(rom_data), 32'h77);
      check("post_rst_level", 32'(level), 32'd0);
      rom_cs = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/jt7759_feed.md
# jt7759_feed

Slave-mode data feeder for the JT7759 ADPCM core. The host CPU pushes sample and header bytes into a small FIFO. The block answers the controller's byte-request handshake (`rom_cs`/`rom_addr` in, `rom_data`/`rom_ok` out) by popping one byte per request. It sits between the CPU bus and the controller's ROM port when `mdn=0`, and it drives the CPU-side DRQ flow control.

## Interface
Parameters:
- `AW`, 4: FIFO address width; depth is 2^AW bytes.
- `DRQ_LVL`, 2^AW-2: `drq` deasserts when the fill level is at or above this value.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `flush`  in  1  synchronous clear of the FIFO and of any pending request; tie to the controller's `busyn` rising edge or to a CPU reset write
- `cpu_wr`  in  1  one-cycle write strobe from the CPU
- `cpu_din`  in  8  byte written by the CPU
- `drq`  out  1  data request to the CPU, high while level < `DRQ_LVL`
- `overflow`  out  1  sticky flag, set when a write arrives while the FIFO is full
- `level`  out  AW+1  current fill count, 0 to 2^AW
- `rom_cs`  in  1  byte request from the controller, held high while waiting
- `rom_addr`  in  17  controller address; used only to detect back-to-back requests
- `rom_data`  out  8  served byte
- `rom_ok`  out  1  `rom_data` is valid for the current request

## Operation
- Reset values: `rom_data`=0, `rom_ok`=0, `drq`=1, `overflow`=0, `level`=0, state IDLE, `cs_l`=0, `addr_l`=0.
- Request event (`req`): `rom_cs` is high and either `cs_l`=0 or `rom_addr`≠`addr_l`. `cs_l` and `addr_l` are registered copies of `rom_cs` and `rom_addr`. The address-change term covers controller states that hold `rom_cs` high across consecutive bytes.
- State machine:
  - IDLE, on `req`: if FIFO non-empty, go to SERVE; else go to WAIT. `rom_ok` goes to 0.
  - WAIT: when FIFO becomes non-empty, go to SERVE. If `rom_cs`=0, go to IDLE with no pop.
  - SERVE: pop the head, load `rom_data`, set `rom_ok`=1, go to HOLD. This is one cycle.
  - HOLD: keep `rom_data` and `rom_ok`.
    - `rom_cs`=0: `rom_ok` goes to 0, go to IDLE.
    - New `req`: `rom_ok` goes to 0, re-evaluate as from IDLE.
- At most one pop per request. A request withdrawn before SERVE pops nothing.
- FIFO write: on `cpu_wr`, if not full, push `cpu_din`. If full, drop the byte and set `overflow`.
- Push and pop in the same cycle: both happen and `level` is unchanged. A push into an empty FIFO while in WAIT lets SERVE run on the next cycle.
- Pointers are AW+1 bits wide and wrap modulo 2^(AW+1).
  - Full: MSBs differ and the low bits are equal.
  - Empty: pointers are equal.
- `flush` has priority over push, pop and `req`. It sets pointers to 0, `level`=0, `overflow`=0, `rom_ok`=0 and state IDLE. `rom_data` keeps its last value.
- `drq` and `level` are registered from the post-update pointers.

## Timing
- Request to `rom_ok` with data available: a `req` registered at cycle N puts the state in SERVE at N+1. `rom_ok`=1 and `rom_data` are valid from N+2.
- Empty FIFO: `rom_ok` rises 2 cycles after the push that makes the FIFO non-empty.
- `rom_ok` falls 1 cycle after `rom_cs` falls or after an address change. The controller samples on `cen_ctl`/`cen_dec`, whose period must be ≥ 2 `clk`, so a stale `rom_ok` is never consumed.
- `drq` and `level` update 1 cycle after the push or pop that changes them.
- Reset mid-request: all outputs return to their reset values asynchronously. The pending request is discarded.

## Structure
- Package `jt7759_pkg` holds the state encoding (IDLE, WAIT, SERVE, HOLD; one-hot, width 4) and the default FIFO AW.
- One sub-module, `jt7759_fifo`: synchronous byte FIFO with push, pop, flush, full, empty and level ports, implemented as a register array. The request state machine and the `req` detection stay in `jt7759_feed`.

## Test plan
- Basic serve: push 0x5A, 0xA5. Raise `rom_cs` at `rom_addr`=0x00003 -> `rom_ok`=1 two cycles later with `rom_data`=0x5A, `level`=1. Change `rom_addr` to 0x00004 with `rom_cs` held -> `rom_ok` drops, then returns with 0xA5, `level`=0.
- Empty wait: raise `rom_cs` with the FIFO empty -> `rom_ok` stays 0. Push 0x3C -> `rom_ok`=1 two cycles later with `rom_data`=0x3C.
- Withdrawn request: raise `rom_cs` with the FIFO empty, drop it after 3 cycles, then push 0x11 -> no pop occurs, `level`=1, `rom_ok` stays 0.
- Full and overflow (AW=4): push 16 bytes -> `level`=16, `drq`=0. Push a 17th byte -> byte dropped, `overflow`=1. Issue `flush` -> `level`=0, `overflow`=0, `drq`=1.
- Simultaneous push and pop: with `level`=4, assert `cpu_wr` in the same cycle as SERVE -> `level` stays 4. Bytes come out in write order across 2^(AW+1)+3 total transfers, which exercises pointer wrap.
- Reset mid-HOLD: assert `rst` while `rom_ok`=1 -> `rom_ok`=0, `rom_data`=0, `level`=0 immediately. The first request after reset waits for fresh data.
